// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Imported by the arbiter top and its round-robin picker.
package fifo_wr_arbiter_pkg;

  localparam int DW_DEF = 16;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr,
// wrapping, returned as one-hot plus index.
module fifo_wr_arbiter_rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  oh_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  always_comb begin
    int j;
    oh_o  = '0;
    idx_o = '0;
    any_o = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr_i) + k;
      if (j >= N) j = j - N;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        oh_o[j]  = 1'b1;
        idx_o    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin owner of the FIFO write port with bounded bursts;
// a write is never issued while full is high.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int DW        = DW_DEF,
  parameter int MAX_BURST = 8
) (
  input  logic                clk_a,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*DW-1:0] din_req,
  output logic [N_REQ-1:0]    ack,
  output logic [N_REQ-1:0]    gnt,
  input  logic                full,
  output logic [DW-1:0]       din_a,
  output logic                wen_a,
  output logic                busy
);

  localparam int PW = clog2(N_REQ);
  localparam int CW = clog2(MAX_BURST) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_BURST - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(N_REQ - 1);

  state_e           state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [PW-1:0]    own_q, own_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic [PW-1:0]    nxt_ptr;
  logic [PW-1:0]    pick_ptr;
  logic [PW-1:0]    pick_idx;
  logic [N_REQ-1:0] pick_oh;
  logic             pick_any;
  logic             own_req;
  logic             rel;

  assign busy    = (state_q == ST_GRANT);
  assign gnt     = gnt_q;
  assign own_req = |(req & gnt_q);
  assign wen_a   = busy & own_req & ~full;
  assign ack     = {N_REQ{wen_a}} & gnt_q;

  assign nxt_ptr  = (own_q == PTR_LAST) ? '0 : own_q + PW'(1);
  // While granted, the picker looks ahead from the post-release pointer
  assign pick_ptr = busy ? nxt_ptr : ptr_q;

  fifo_wr_arbiter_rr_pick #(
    .N  (N_REQ),
    .PW (PW)
  ) u_pick (
    .req_i (req),
    .ptr_i (pick_ptr),
    .oh_o  (pick_oh),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    din_a = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_q[i]) din_a = din_a | din_req[i*DW +: DW];
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    own_d   = own_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    rel     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          state_d = ST_GRANT;
          gnt_d   = pick_oh;
          own_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      ST_GRANT: begin
        rel = !own_req || (wen_a && (cnt_q == CNT_LAST));
        if (rel) begin
          ptr_d = nxt_ptr;
          cnt_d = '0;
          if (pick_any) begin
            gnt_d = pick_oh;
            own_d = pick_idx;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
            own_d   = '0;
          end
        end else if (wen_a) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_a or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      own_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      own_q   <= own_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
